// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned ADDR_W_DEF   = 7;
  localparam int unsigned INSTR_W_DEF  = 32;
  localparam int unsigned MAX_WAIT_DEF = 8;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN,
    HALT
  } if_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid flag plus the captured instruction and its address.
module if_id_reg
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; payload fields are reset too because decode
  // observes id_instr/id_pc directly and must see zeros out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one imem request per pc, result held in IF/ID until decode takes it.
// Optional build macro FETCH_TIMEOUT_EN adds an ack timeout that halts the stage with fetch_err.
module if_fetch
  import if_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned INSTR_W  = INSTR_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic               pc_advance,
  input  logic               redirect,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               fetch_err
);

  if (ADDR_W < 3 || MAX_WAIT < 1) begin : g_param_check
    $error("if_fetch: ADDR_W must be >= 3 and MAX_WAIT >= 1");
  end

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              id_load;
  logic              id_clr;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Wraps modulo 2^ADDR_W; pc_in alignment is deliberately not checked.
  assign pc_plus4  = pc_in + ADDR_W'(4);
  assign imem_addr = addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    imem_req   = 1'b0;
    pc_advance = 1'b0;
    id_load    = 1'b0;
    id_clr     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = '0;
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        addr_d  = pc_in;
        state_d = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          // A redirected request that is not yet acked is still owed by memory.
          state_d = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          id_load    = 1'b1;
          pc_advance = 1'b1;
          state_d    = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      HOLD: begin
        if (redirect) begin
          id_clr  = 1'b1;
          state_d = IDLE;
        end else if (id_ready) begin
          // pc register already stepped when this word was captured.
          id_clr  = 1'b1;
          addr_d  = pc_in;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        if (imem_ack) begin
          state_d = IDLE;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      HALT: begin
        state_d = HALT;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (id_load),
    .clr_i  (id_clr),
    .instr_i(imem_rdata),
    .pc_i   (addr_q),
    .valid_o(id_valid),
    .instr_o(id_instr),
    .pc_o   (id_pc)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: pc register, instruction memory and decode modelled around the DUT.
module tb_if_fetch;

  localparam int AW     = 7;
  localparam int IW     = 32;
  localparam int MW     = 8;
  localparam int PC_MOD = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] pc_in = '0;
  logic [AW-1:0] pc_plus4;
  logic          pc_advance;
  logic          redirect = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          id_valid;
  logic          id_ready = 1'b0;
  logic [IW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic          fetch_err;

  if_fetch #(.ADDR_W(AW), .INSTR_W(IW), .MAX_WAIT(MW)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_plus4  (pc_plus4),
    .pc_advance(pc_advance),
    .redirect  (redirect),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .id_valid  (id_valid),
    .id_ready  (id_ready),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .fetch_err (fetch_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Program image: every address holds a distinct word.
  function automatic logic [31:0] mem_word(input int a);
    if (a == 0) return 32'h0050_0093;
    return 32'h0000_0013 | (32'(a) << 20);
  endfunction

  // Environment and reference model state.
  int          exp_pc;      // address of the next instruction decode must see
  int          pc_nxt;      // pc register value after the last edge
  bit          mem_en;
  bit          mem_busy;
  int          mem_wait;
  int          mem_addr;
  int          lat_cfg;     // <0: random latency 0..3
  int          ready_cfg;   // 0/1 fixed, 2 random
  bit          redir_pend;
  bit          redir_rand;
  int          redir_tgt;
  int          adv_cnt;
  bit          prev_hold;
  logic [31:0] prev_instr;
  int          prev_pc;

  task automatic cycle();
    @(negedge clk);
    pc_in    = AW'(pc_nxt);
    imem_ack = 1'b0;
    if (mem_en) begin
      if (!mem_busy && imem_req) begin
        mem_busy = 1'b1;
        mem_wait = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        mem_addr = int'(imem_addr);
      end
      if (mem_busy) begin
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 1'b0;
        end else begin
          mem_wait--;
        end
      end
    end
    id_ready = (ready_cfg == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_cfg);
    redirect = 1'b0;
    if (imem_req || id_valid) begin
      if (redir_pend) begin
        redirect   = 1'b1;
        redir_pend = 1'b0;
      end else if (redir_rand && $urandom_range(0, 9) == 0) begin
        redirect  = 1'b1;
        redir_tgt = int'($urandom_range(0, PC_MOD / 4 - 1)) * 4;
      end
    end
    #1;
    check("pc_plus4", 32'(pc_plus4), 32'((int'(pc_in) + 4) % PC_MOD));
    check("pc_advance", 32'(pc_advance), 32'(imem_req && imem_ack && !redirect));
    if (imem_req) check("imem_addr", 32'(imem_addr), 32'(exp_pc));
    if (id_valid) begin
      check("id_pc", 32'(id_pc), 32'(exp_pc));
      check("id_instr", id_instr, mem_word(exp_pc));
    end
    if (prev_hold) begin
      check("hold_valid", 32'(id_valid), 32'(1));
      check("hold_instr", id_instr, prev_instr);
      check("hold_pc", 32'(id_pc), 32'(prev_pc));
    end
    prev_hold  = id_valid && !id_ready && !redirect;
    prev_instr = id_instr;
    prev_pc    = int'(id_pc);
    if (pc_advance) adv_cnt++;
    if (redirect) exp_pc = redir_tgt;
    else if (id_valid && id_ready) exp_pc = (exp_pc + 4) % PC_MOD;
    if (redirect) pc_nxt = redir_tgt;
    else if (pc_advance) pc_nxt = (int'(pc_in) + 4) % PC_MOD;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 32'(imem_req), 32'(0));
    check({tag, "_addr"}, 32'(imem_addr), 32'(0));
    check({tag, "_adv"}, 32'(pc_advance), 32'(0));
    check({tag, "_valid"}, 32'(id_valid), 32'(0));
    check({tag, "_instr"}, id_instr, 32'(0));
    check({tag, "_pc"}, 32'(id_pc), 32'(0));
    check({tag, "_err"}, 32'(fetch_err), 32'(0));
  endtask

  task automatic do_reset(input int start_pc);
    @(negedge clk);
    rst      = 1'b0;
    imem_ack = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    #1;
    check_zero("rst");
    @(negedge clk);
    exp_pc    = start_pc;
    pc_nxt    = start_pc;
    pc_in     = AW'(start_pc);
    mem_busy  = 1'b0;
    prev_hold = 1'b0;
    adv_cnt   = 0;
    rst       = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [31:0] held;
    int          a0;
    bit          stalled, seen124, done, got, saw_valid;

    mem_en     = 1'b1;
    lat_cfg    = 0;
    ready_cfg  = 0;
    redir_pend = 1'b0;
    redir_rand = 1'b0;
    redir_tgt  = 0;
    do_reset(0);

    // First fetch with immediate ack, then accept and step to pc 4.
    cycle();
    check("t1_req", 32'(imem_req), 32'(1));
    check("t1_adv", 32'(pc_advance), 32'(1));
    ready_cfg = 1;
    cycle();
    check("t1_valid", 32'(id_valid), 32'(1));
    check("t1_instr", id_instr, 32'h0050_0093);
    check("t1_pc", 32'(id_pc), 32'(0));
    check("t1_adv_once", 32'(adv_cnt), 32'(1));
    cycle();
    check("t1_next_req", 32'(imem_req), 32'(1));
    check("t1_next_addr", 32'(imem_addr), 32'(4));

    // Stream through the address space with slow memory and a decode stall at pc 8.
    lat_cfg = 3;
    stalled = 1'b0;
    seen124 = 1'b0;
    done    = 1'b0;
    for (int i = 0; i < 1500 && !done; i++) begin
      cycle();
      if (!stalled && imem_req && imem_addr == AW'(8)) ready_cfg = 0;
      if (!stalled && id_valid && id_pc == AW'(8)) begin
        held = id_instr;
        a0   = adv_cnt;
        repeat (4) cycle();
        check("stall_valid", 32'(id_valid), 32'(1));
        check("stall_instr", id_instr, held);
        check("stall_pc", 32'(id_pc), 32'(8));
        check("stall_no_adv", 32'(adv_cnt), 32'(a0));
        ready_cfg = 1;
        stalled   = 1'b1;
      end
      if (!seen124 && imem_req && imem_addr == AW'(124)) begin
        check("wrap_plus4", 32'(pc_plus4), 32'(0));
        seen124 = 1'b1;
      end
      if (seen124 && imem_req && imem_addr == AW'(0)) done = 1'b1;
    end
    check("wrap_addr0_reached", 32'(done), 32'(1));

    // Redirect in FETCH before the ack; memory acks later in DRAIN.
    redir_pend = 1'b1;
    redir_tgt  = 40;
    a0         = adv_cnt;
    got        = 1'b0;
    saw_valid  = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (id_valid) saw_valid = 1'b1;
      if (imem_req && imem_addr == AW'(40)) got = 1'b1;
    end
    check("redir_fetch_40", 32'(got), 32'(1));
    check("redir_no_valid", 32'(saw_valid), 32'(0));
    check("redir_no_adv", 32'(adv_cnt), 32'(a0));

    // Redirect and id_ready together in HOLD: redirect wins.
    ready_cfg = 0;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (id_valid) got = 1'b1;
    end
    check("hr_hold_reached", 32'(got), 32'(1));
    ready_cfg  = 1;
    redir_pend = 1'b1;
    redir_tgt  = 100;
    cycle();
    cycle();
    check("hr_valid_drop", 32'(id_valid), 32'(0));
    ready_cfg = 0;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (id_valid) got = 1'b1;
    end
    check("hr_refetch_pc", 32'(id_pc), 32'(100));
    check("hr_refetch_instr", id_instr, mem_word(100));

    // Asynchronous reset in the middle of a FETCH, then a stray ack.
    lat_cfg   = 5;
    ready_cfg = 1;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cycle();
      if (imem_req && !imem_ack) got = 1'b1;
    end
    check("ar_in_fetch", 32'(got), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check_zero("ar");
    @(negedge clk);
    rst        = 1'b1;
    pc_in      = AW'(60);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    redirect   = 1'b0;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check("stray_no_valid", 32'(id_valid), 32'(0));
    check("stray_fetch_req", 32'(imem_req), 32'(1));
    check("stray_fetch_addr", 32'(imem_addr), 32'(60));
    exp_pc    = 60;
    pc_nxt    = 60;
    mem_busy  = 1'b0;
    prev_hold = 1'b0;
    repeat (10) cycle();

    // Randomized traffic against the model.
    lat_cfg    = -1;
    ready_cfg  = 2;
    redir_rand = 1'b1;
    a0         = adv_cnt;
    repeat (3000) cycle();
    redir_rand = 1'b0;
    check("rand_progress", 32'((adv_cnt - a0) > 100), 32'(1));

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: halt after MAX_WAIT fetch cycles.
    mem_en = 1'b0;
    do_reset(16);
    repeat (MW) cycle();
    check("to_err_before", 32'(fetch_err), 32'(0));
    check("to_req_before", 32'(imem_req), 32'(1));
    cycle();
    check("to_err", 32'(fetch_err), 32'(1));
    check("to_req_off", 32'(imem_req), 32'(0));
    repeat (10) cycle();
    check("to_err_sticky", 32'(fetch_err), 32'(1));
    check("to_halt_req", 32'(imem_req), 32'(0));
    check("to_halt_valid", 32'(id_valid), 32'(0));
`else
    check("fetch_err_tied", 32'(fetch_err), 32'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
